// File: rtl/phase_2_preadd_mult.sv
// Second DSP48A1-style stage: D+/-B pre-adder, A1/B1 registers, unsigned multiplier and M register.
// Define PHASE2_PREADD_OVF_EN to add the registered preadd_ovf carry/borrow output.
module phase_2_preadd_mult #(
   parameter int unsigned WIDTH     = 18,
   parameter int unsigned A1REG     = 1,
   parameter int unsigned B1REG     = 1,
   parameter int unsigned MREG      = 1,
   parameter int unsigned OPMODEREG = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [7:0]         opmode,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   b_in,
   input  logic [WIDTH-1:0]   d_in,
   input  logic               ceopmode,
   input  logic               cea1,
   input  logic               ceb1,
   input  logic               cem,
   input  logic               in_valid,
   output logic [7:0]         opmode_q,
   output logic [WIDTH-1:0]   bcout,
   output logic [2*WIDTH-1:0] m_out,
`ifdef PHASE2_PREADD_OVF_EN
   output logic               preadd_ovf,
`endif
   output logic               out_valid
);

   if (A1REG != B1REG) begin : g_cfg_err
      $error("phase_2_preadd_mult: A1REG must equal B1REG");
   end

   if (OPMODEREG != 0) begin : g_opmode_reg
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            opmode_q <= '0;
         end else if (ceopmode) begin
            opmode_q <= opmode;
         end
      end
   end else begin : g_opmode_comb
      assign opmode_q = opmode;
   end

   logic [WIDTH-1:0] pre;
   logic [WIDTH-1:0] b1_d;
   logic [WIDTH-1:0] a1;
   logic [WIDTH-1:0] b1;
   logic             v1;

`ifdef PHASE2_PREADD_OVF_EN
   // One extra bit holds the carry (add) or borrow (sub) out of the WIDTH-bit pre-adder.
   logic [WIDTH:0] pre_full;
   logic           ovf_d;

   always_comb begin
      if (opmode_q[6]) begin
         pre_full = {1'b0, d_in} - {1'b0, b_in};
      end else begin
         pre_full = {1'b0, d_in} + {1'b0, b_in};
      end
   end

   assign pre   = pre_full[WIDTH-1:0];
   assign ovf_d = opmode_q[4] & pre_full[WIDTH];

   if (B1REG != 0) begin : g_ovf_reg
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            preadd_ovf <= 1'b0;
         end else if (ceb1) begin
            preadd_ovf <= ovf_d;
         end
      end
   end else begin : g_ovf_comb
      assign preadd_ovf = ovf_d;
   end
`else
   assign pre = opmode_q[6] ? d_in - b_in : d_in + b_in;
`endif

   assign b1_d = opmode_q[4] ? pre : b_in;

   // The valid token shares each stage's clock enable so data and valid never separate.
   if (B1REG != 0) begin : g_b1_reg
      logic [WIDTH-1:0] b1_q;
      logic             v1_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            b1_q <= '0;
            v1_q <= 1'b0;
         end else if (ceb1) begin
            b1_q <= b1_d;
            v1_q <= in_valid;
         end
      end

      assign b1 = b1_q;
      assign v1 = v1_q;
   end else begin : g_b1_comb
      assign b1 = b1_d;
      assign v1 = in_valid;
   end

   if (A1REG != 0) begin : g_a1_reg
      logic [WIDTH-1:0] a1_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            a1_q <= '0;
         end else if (cea1) begin
            a1_q <= a_in;
         end
      end

      assign a1 = a1_q;
   end else begin : g_a1_comb
      assign a1 = a_in;
   end

   logic [2*WIDTH-1:0] p;

   assign p     = (2*WIDTH)'(a1) * (2*WIDTH)'(b1);
   assign bcout = b1;

   if (MREG != 0) begin : g_m_reg
      logic [2*WIDTH-1:0] m_q;
      logic               v2_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            m_q  <= '0;
            v2_q <= 1'b0;
         end else if (cem) begin
            m_q  <= p;
            v2_q <= v1;
         end
      end

      assign m_out     = m_q;
      assign out_valid = v2_q;
   end else begin : g_m_comb
      assign m_out     = p;
      assign out_valid = v1;
   end

endmodule

// File: tb/tb_phase_2_preadd_mult.sv
// Scoreboard bench for phase_2_preadd_mult: a registered default instance plus an all-bypass
// instance sharing the same inputs.
module tb_phase_2_preadd_mult;

   localparam int unsigned W = 18;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [7:0]     opmode;
   logic [W-1:0]   a_in, b_in, d_in;
   logic           ceopmode, cea1, ceb1, cem, in_valid;
   logic [7:0]     opmode_q, c_opmode_q;
   logic [W-1:0]   bcout, c_bcout;
   logic [2*W-1:0] m_out, c_m_out;
   logic           out_valid, c_out_valid;
`ifdef PHASE2_PREADD_OVF_EN
   logic           preadd_ovf, c_preadd_ovf;
`endif

   int             checks = 0;
   int             errors = 0;
   logic [2*W-1:0] exp_q[$];
   logic           cem_edge = 1'b0;

   always #5 clk = ~clk;

   phase_2_preadd_mult #(
      .WIDTH(W), .A1REG(1), .B1REG(1), .MREG(1), .OPMODEREG(1)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .opmode(opmode), .a_in(a_in), .b_in(b_in), .d_in(d_in),
      .ceopmode(ceopmode), .cea1(cea1), .ceb1(ceb1), .cem(cem), .in_valid(in_valid),
      .opmode_q(opmode_q), .bcout(bcout), .m_out(m_out),
`ifdef PHASE2_PREADD_OVF_EN
      .preadd_ovf(preadd_ovf),
`endif
      .out_valid(out_valid)
   );

   phase_2_preadd_mult #(
      .WIDTH(W), .A1REG(0), .B1REG(0), .MREG(0), .OPMODEREG(0)
   ) u_comb (
      .clk(clk), .rst_n(rst_n), .opmode(opmode), .a_in(a_in), .b_in(b_in), .d_in(d_in),
      .ceopmode(ceopmode), .cea1(cea1), .ceb1(ceb1), .cem(cem), .in_valid(in_valid),
      .opmode_q(c_opmode_q), .bcout(c_bcout), .m_out(c_m_out),
`ifdef PHASE2_PREADD_OVF_EN
      .preadd_ovf(c_preadd_ovf),
`endif
      .out_valid(c_out_valid)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] d,
                        input logic [2*W-1:0] m);
      a_in     = a;
      b_in     = b;
      d_in     = d;
      in_valid = 1'b1;
      exp_q.push_back(m);
      tick();
      in_valid = 1'b0;
   endtask

   // Inputs only change 1 ns after an edge, so this is the cem the M register saw.
   always @(posedge clk) cem_edge = cem;

   // A new product is present whenever out_valid is high after an edge where M was enabled.
   always @(negedge clk) begin
      if (out_valid && cem_edge) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_product: got %0h expected none", m_out);
         end else begin
            check("m_out", {28'd0, m_out}, {28'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      rst_n    = 1'b1;
      opmode   = '0;
      a_in     = '0;
      b_in     = '0;
      d_in     = '0;
      ceopmode = 1'b1;
      cea1     = 1'b1;
      ceb1     = 1'b1;
      cem      = 1'b1;
      in_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("rst_opmode_q", opmode_q, 0);
      check("rst_bcout", bcout, 0);
      check("rst_m_out", m_out, 0);
      check("rst_out_valid", out_valid, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Add path: 5+3=8, 4*8=32, latency two cycles.
      opmode = 8'h10;
      tick();
      issue(18'd4, 18'd3, 18'd5, 36'd32);
      check("t1_bcout", bcout, 18'd8);
      check("t1_opmode_q", opmode_q, 8'h10);
      check("t1_valid_early", out_valid, 0);
`ifdef PHASE2_PREADD_OVF_EN
      check("t1_ovf", preadd_ovf, 0);
`endif
      tick();
      check("t1_valid_lat2", out_valid, 1);

      // Subtract wraps: 3-5 = 3FFFE, 2*3FFFE = 7FFFC.
      opmode = 8'h50;
      tick();
      issue(18'd2, 18'd5, 18'd3, 36'h7FFFC);
      check("t2_bcout_wrap", bcout, 18'h3FFFE);
`ifdef PHASE2_PREADD_OVF_EN
      check("t2_ovf_borrow", preadd_ovf, 1);
`endif

      // Add carry-out: 3FFFF+2 = 1 (carry), 7*1 = 7.
      opmode = 8'h10;
      tick();
      issue(18'd7, 18'd2, 18'h3FFFF, 36'd7);
      check("t2b_bcout_carry", bcout, 18'd1);
`ifdef PHASE2_PREADD_OVF_EN
      check("t2b_ovf_carry", preadd_ovf, 1);
`endif

      // B direct, full-scale product.
      opmode = 8'h00;
      tick();
      issue(18'h3FFFF, 18'h3FFFF, 18'h00123, 36'hFFFF80001);
      check("t3_bcout", bcout, 18'h3FFFF);
`ifdef PHASE2_PREADD_OVF_EN
      check("t3_ovf_off", preadd_ovf, 0);
`endif
      tick();
      tick();

      // opmode register holds when ceopmode is low.
      ceopmode = 1'b0;
      opmode   = 8'h50;
      tick();
      check("opmode_hold", opmode_q, 8'h00);
      ceopmode = 1'b1;
      tick();
      check("opmode_load", opmode_q, 8'h50);
      opmode = 8'h10;
      tick();

      // Stream of three with a two-cycle stall.
      issue(18'd1, 18'd1, 18'd1, 36'd2);
      issue(18'd3, 18'd1, 18'd4, 36'd15);
      cem  = 1'b0;
      cea1 = 1'b0;
      ceb1 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("stall_m_hold", m_out, 36'd2);
         check("stall_valid_hold", out_valid, 1);
         check("stall_bcout_hold", bcout, 18'd5);
      end
      cem  = 1'b1;
      cea1 = 1'b1;
      ceb1 = 1'b1;
      issue(18'd6, 18'd0, 18'd10, 36'd60);
      check("stream_bcout", bcout, 18'd10);
      tick();
      tick();
      check("stream_drained", out_valid, 0);

      // Asynchronous reset between edges while a product is valid.
      issue(18'd2, 18'd2, 18'd2, 36'd8);
      tick();
      check("t5_valid_before_rst", out_valid, 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_m_out", m_out, 0);
      check("t5_rst_bcout", bcout, 0);
      check("t5_rst_valid", out_valid, 0);
      check("t5_rst_opmode_q", opmode_q, 0);
      #1 rst_n = 1'b1;
      tick();
      tick();
      tick();
      check("t5_no_token_after_rst", out_valid, 0);

      // All-bypass instance is purely combinational.
      opmode   = 8'h10;
      a_in     = 18'd4;
      b_in     = 18'd3;
      d_in     = 18'd5;
      in_valid = 1'b1;
      #1;
      check("c_bcout_add", c_bcout, 18'd8);
      check("c_m_add", c_m_out, 36'd32);
      check("c_valid_hi", c_out_valid, 1);
      opmode = 8'h00;
      a_in   = 18'h3FFFF;
      b_in   = 18'h3FFFF;
      #1;
      check("c_m_full", c_m_out, 36'hFFFF80001);
      check("c_bcout_direct", c_bcout, 18'h3FFFF);
      opmode   = 8'h50;
      a_in     = 18'd2;
      b_in     = 18'd5;
      d_in     = 18'd3;
      in_valid = 1'b0;
      #1;
      check("c_bcout_sub", c_bcout, 18'h3FFFE);
      check("c_m_sub", c_m_out, 36'h7FFFC);
      check("c_valid_lo", c_out_valid, 0);
`ifdef PHASE2_PREADD_OVF_EN
      check("c_ovf_borrow", c_preadd_ovf, 1);
`endif
      tick();
      tick();
      tick();
      check("scoreboard_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
